// File: rtl/fifo_buffer.sv
// Synchronous FIFO buffer with run/drain/idle sequencing and sticky error flags.
// Define FIFO_STATS_EN to add the peak_count output and stats_clr input.
module fifo_buffer #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
`ifdef FIFO_STATS_EN
    input  logic                     stats_clr,
    output logic [$clog2(DEPTH):0]   peak_count,
`endif
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   count,
    output logic [1:0]               state,
    output logic                     ovf,
    output logic                     udf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        DRAIN = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] rd_data_q;
    logic             rd_valid_q;
    logic             ovf_q, udf_q;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic wr_acc, rd_acc;

    assign full        = (count_q == CW'(DEPTH));
    assign empty       = (count_q == '0);
    assign almost_full = (count_q >= CW'(AF_LEVEL));

    // Writes need start as well as RUN so a stop request refuses them at once
    assign wr_acc = wr_en & ~full & (state_q == RUN) & start;
    assign rd_acc = rd_en & ~empty & (state_q != IDLE);

    always_comb begin
        count_d = count_q;
        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = RUN;
            end
            RUN: begin
                if (!start) state_d = (count_d != '0) ? DRAIN : IDLE;
            end
            DRAIN: begin
                if (start)                 state_d = RUN;
                else if (count_d == '0)    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            rd_valid_q <= rd_acc;
            if (wr_acc) wptr_q <= wptr_q + AW'(1);
            if (rd_acc) begin
                rptr_q    <= rptr_q + AW'(1);
                rd_data_q <= mem_q[rptr_q];
            end
            if (wr_en & ~wr_acc) ovf_q <= 1'b1;
            if (rd_en & ~rd_acc) udf_q <= 1'b1;
        end
    end

    // Storage is intentionally left unreset
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wptr_q] <= wr_data;
    end

`ifdef FIFO_STATS_EN
    logic [CW-1:0] peak_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 peak_q <= '0;
        else if (stats_clr)         peak_q <= count_q;
        else if (count_q > peak_q)  peak_q <= count_q;
    end

    assign peak_count = peak_q;
`endif

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign count    = count_q;
    assign state    = state_q;
    assign ovf      = ovf_q;
    assign udf      = udf_q;

endmodule

// File: tb/tb_fifo_buffer.sv
// Bench for fifo_buffer: directed scenarios plus random traffic
// compared every cycle against a queue-based model.
module tb_fifo_buffer;

    localparam int WIDTH    = 8;
    localparam int DEPTH    = 8;
    localparam int AF_LEVEL = 6;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start, wr_en, rd_en;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid, full, empty, almost_full, ovf, udf;
    logic [3:0]       count;
    logic [1:0]       state;

    int n_chk  = 0;
    int n_pass = 0;

    fifo_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .full(full),
        .empty(empty), .almost_full(almost_full), .count(count),
        .state(state), .ovf(ovf), .udf(udf)
    );

    always #5 clk = ~clk;

    // Reference model: a queue plus the three-state sequencing rules
    int         m_q[$];
    int         m_state;
    int         m_rd_data;
    bit         m_rd_valid, m_ovf, m_udf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_state    = 0;
            m_rd_data  = 0;
            m_rd_valid = 0;
            m_ovf      = 0;
            m_udf      = 0;
        end else begin
            bit wa, ra;
            int n;
            wa = wr_en && (m_q.size() < DEPTH) && (m_state == 1) && start;
            ra = rd_en && (m_q.size() > 0) && (m_state != 0);
            if (ra) m_rd_data = m_q.pop_front();
            if (wa) m_q.push_back(int'(wr_data));
            m_rd_valid = ra;
            if (wr_en && !wa) m_ovf = 1;
            if (rd_en && !ra) m_udf = 1;
            n = m_q.size();
            case (m_state)
                0: if (start) m_state = 1;
                1: if (!start) m_state = (n != 0) ? 2 : 0;
                2: if (start) m_state = 1; else if (n == 0) m_state = 0;
                default: m_state = 0;
            endcase
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("count",    int'(count),       m_q.size());
            chk("full",     int'(full),        int'(m_q.size() == DEPTH));
            chk("empty",    int'(empty),       int'(m_q.size() == 0));
            chk("afull",    int'(almost_full), int'(m_q.size() >= AF_LEVEL));
            chk("state",    int'(state),       m_state);
            chk("rd_data",  int'(rd_data),     m_rd_data);
            chk("rd_valid", int'(rd_valid),    int'(m_rd_valid));
            chk("ovf",      int'(ovf),         int'(m_ovf));
            chk("udf",      int'(udf),         int'(m_udf));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en   = 0;
        rd_en   = 0;
        wr_data = '0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        #2;
        rst_n = 1;
    endtask

    initial begin
        rst_n = 0;
        start = 0;
        idle_inputs();
        #12;
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_state", int'(state), 0);
        chk("rst_ovf",   int'(ovf),   0);
        rst_n = 1;

        // Fill to full, then one refused write
        start = 1;
        tick();
        chk("t1_state", int'(state), 1);
        for (int i = 0; i < 8; i++) begin
            wr_en   = 1;
            wr_data = 8'h11 + 8'(i);
            tick();
            chk("t1_afull", int'(almost_full), int'(i + 1 >= 6));
        end
        chk("t1_count", int'(count), 8);
        chk("t1_full",  int'(full), 1);
        chk("t1_ovf0",  int'(ovf), 0);
        wr_data = 8'h99;
        tick();
        chk("t1_ovf1",   int'(ovf), 1);
        chk("t1_count9", int'(count), 8);
        idle_inputs();

        // Drain in order, then one refused read
        for (int i = 0; i < 8; i++) begin
            rd_en = 1;
            tick();
            chk("t2_data",  int'(rd_data), 8'h11 + i);
            chk("t2_valid", int'(rd_valid), 1);
        end
        chk("t2_empty", int'(empty), 1);
        tick();
        chk("t2_udf",    int'(udf), 1);
        chk("t2_novld",  int'(rd_valid), 0);
        chk("t2_hold",   int'(rd_data), 8'h18);
        idle_inputs();

        // Simultaneous read/write across pointer wrap
        for (int i = 0; i < 4; i++) begin
            wr_en   = 1;
            wr_data = 8'hA0 + 8'(i);
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            wr_en   = 1;
            rd_en   = 1;
            wr_data = 8'hB0 + 8'(i);
            tick();
            chk("t3_count", int'(count), 4);
            chk("t3_data", int'(rd_data), (i < 4) ? (8'hA0 + i) : (8'hB0 + i - 4));
        end
        idle_inputs();

        // Drain sequence
        do_reset();
        start = 1;
        tick();
        for (int i = 0; i < 3; i++) begin
            wr_en   = 1;
            wr_data = 8'hC0 + 8'(i);
            tick();
        end
        wr_en = 0;
        start = 0;
        tick();
        chk("t4_drain", int'(state), 2);
        wr_en = 1;
        tick();
        chk("t4_ovf",   int'(ovf), 1);
        chk("t4_count", int'(count), 3);
        wr_en = 0;
        for (int i = 0; i < 3; i++) begin
            rd_en = 1;
            tick();
            chk("t4_data",  int'(rd_data), 8'hC0 + i);
            chk("t4_state", int'(state), (i < 2) ? 2 : 0);
        end
        chk("t4_empty", int'(empty), 1);
        idle_inputs();

        // Asynchronous reset in the middle of a burst
        do_reset();
        start = 1;
        tick();
        for (int i = 0; i < 5; i++) begin
            wr_en   = 1;
            wr_data = 8'hD0 + 8'(i);
            tick();
        end
        chk("t5_count5", int'(count), 5);
        #3;
        rst_n = 0;
        #1;
        chk("t5_count", int'(count), 0);
        chk("t5_state", int'(state), 0);
        chk("t5_empty", int'(empty), 1);
        chk("t5_full",  int'(full), 0);
        chk("t5_vld",   int'(rd_valid), 0);
        chk("t5_data",  int'(rd_data), 0);
        #2;
        rst_n = 1;
        start = 0;
        idle_inputs();
        rd_en = 1;
        tick();
        chk("t5_udf",  int'(udf), 1);
        chk("t5_nvld", int'(rd_valid), 0);
        idle_inputs();

        // Random traffic with shifting write/read bias
        do_reset();
        for (int p = 0; p < 4; p++) begin
            int wp, rp;
            wp = (p % 2 == 0) ? 75 : 30;
            rp = (p % 2 == 0) ? 30 : 75;
            for (int c = 0; c < 400; c++) begin
                start   = ($urandom_range(0, 99) < 88);
                wr_en   = ($urandom_range(0, 99) < wp);
                rd_en   = ($urandom_range(0, 99) < rp);
                wr_data = 8'($urandom);
                tick();
            end
        end
        idle_inputs();
        start = 0;
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
